// File: rtl/csa_key_loader.sv
// ---------------------------------------------------------------------------
// csa_key_loader
//
// Control-word scheduler in front of the CSA decrypt core. Two requesters
// (even and odd) each hand over a 64-bit control word. Every CW waits in its
// own slot until the core's single key-load port is free. The CW for the
// parity that the in-flight packet is using is never loaded while that packet
// is active. One key-schedule run happens at a time, and the loader tracks
// whether each parity's key schedule is complete and current.
//
// Handshake: a slot accepts a CW on any rising edge where x_cw_valid and
// x_cw_ready are both high. x_cw_ready comes straight from the slot's pend
// flag, so it has no combinational dependence on x_cw_valid. A requester may
// drop valid or change data only after the accepting edge.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   even_cw_valid  even CW offered
//   even_cw        even CW value
//   even_cw_ready  even slot empty
//   odd_cw_valid   odd CW offered
//   odd_cw         odd CW value
//   odd_cw_ready   odd slot empty
//   pkt_active     decrypt core is inside a scrambled TS packet
//   pkt_parity     parity used by that packet (0 even, 1 odd)
//   flush          synchronous pulse: drop pending CWs, invalidate both keys
//   key_en         one-cycle start pulse to the decrypt core
//   even_odd       parity of the CW on ck, held while busy
//   ck             CW driven to the core, held while busy
//   busy           key schedule run in progress
//   load_done      one-cycle pulse when a run completes
//   even_key_valid even key schedule complete and current
//   odd_key_valid  odd key schedule complete and current
// ---------------------------------------------------------------------------
module csa_key_loader #(
  parameter int KS_CYCLES = 56,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        even_cw_valid,
  input  logic [63:0] even_cw,
  output logic        even_cw_ready,
  input  logic        odd_cw_valid,
  input  logic [63:0] odd_cw,
  output logic        odd_cw_ready,
  input  logic        pkt_active,
  input  logic        pkt_parity,
  input  logic        flush,
  output logic        key_en,
  output logic        even_odd,
  output logic [63:0] ck,
  output logic        busy,
  output logic        load_done,
  output logic        even_key_valid,
  output logic        odd_key_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(KS_CYCLES - 1);

  state_t           state;
  state_t           state_next;

  logic             pend_even;
  logic             pend_odd;
  logic [63:0]      slot_even;
  logic [63:0]      slot_odd;
  logic [CNT_W-1:0] cnt;
  logic             last_served;

  logic             even_elig;
  logic             odd_elig;
  logic             accept_even;
  logic             accept_odd;
  logic             issue;
  logic             issue_odd;
  logic             finish;

  assign even_cw_ready = ~pend_even;
  assign odd_cw_ready  = ~pend_odd;

  // A flush cycle discards any handshake that happens in the same cycle.
  assign accept_even = even_cw_valid & ~pend_even & ~flush;
  assign accept_odd  = odd_cw_valid  & ~pend_odd  & ~flush;

  // A slot may not load while the active packet uses that parity.
  assign even_elig = pend_even & ~(pkt_active & ~pkt_parity);
  assign odd_elig  = pend_odd  & ~(pkt_active &  pkt_parity);

  // -------------------------------------------------------------------------
  // FSM next-state and decision logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_odd  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (even_elig || odd_elig) begin
          issue = 1'b1;
          // When both slots are eligible, serve the parity that was not
          // served last, so one requester cannot starve the other.
          if (even_elig && odd_elig) begin
            issue_odd = ~last_served;
          end else begin
            issue_odd = odd_elig;
          end
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (flush) begin
      state_next = IDLE;
      issue      = 1'b0;
      issue_odd  = 1'b0;
      finish     = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Slots
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_even <= 1'b0;
      pend_odd  <= 1'b0;
      slot_even <= '0;
      slot_odd  <= '0;
    end else begin
      if (accept_even) begin
        slot_even <= even_cw;
      end
      if (accept_odd) begin
        slot_odd <= odd_cw;
      end

      if (flush) begin
        pend_even <= 1'b0;
      end else if (issue && !issue_odd) begin
        pend_even <= 1'b0;
      end else if (accept_even) begin
        pend_even <= 1'b1;
      end

      if (flush) begin
        pend_odd <= 1'b0;
      end else if (issue && issue_odd) begin
        pend_odd <= 1'b0;
      end else if (accept_odd) begin
        pend_odd <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Key-load port, schedule counter and status
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_en         <= 1'b0;
      load_done      <= 1'b0;
      busy           <= 1'b0;
      cnt            <= '0;
      ck             <= '0;
      even_odd       <= 1'b0;
      last_served    <= 1'b1;
      even_key_valid <= 1'b0;
      odd_key_valid  <= 1'b0;
    end else begin
      key_en    <= issue;
      load_done <= finish;

      if (flush) begin
        busy <= 1'b0;
      end else if (issue) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end

      // The counter loads only at issue and holds at zero; it never wraps.
      if (flush) begin
        cnt <= '0;
      end else if (issue) begin
        cnt <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      // ck and even_odd keep their last value through a flush.
      if (issue) begin
        ck          <= issue_odd ? slot_odd : slot_even;
        even_odd    <= issue_odd;
        last_served <= issue_odd;
      end

      if (flush) begin
        even_key_valid <= 1'b0;
      end else if (issue && !issue_odd) begin
        even_key_valid <= 1'b0;
      end else if (finish && !even_odd) begin
        even_key_valid <= 1'b1;
      end

      if (flush) begin
        odd_key_valid <= 1'b0;
      end else if (issue && issue_odd) begin
        odd_key_valid <= 1'b0;
      end else if (finish && even_odd) begin
        odd_key_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csa_key_loader.sv
// ---------------------------------------------------------------------------
// tb_csa_key_loader
//
// Directed bench for csa_key_loader with KS_CYCLES=56. Inputs change on the
// falling edge, and outputs are sampled on the falling edge. The one exception
// is the asynchronous-reset check, which is sampled between edges.
// ---------------------------------------------------------------------------
module tb_csa_key_loader;

  logic        clk;
  logic        rst;
  logic        even_cw_valid;
  logic [63:0] even_cw;
  logic        even_cw_ready;
  logic        odd_cw_valid;
  logic [63:0] odd_cw;
  logic        odd_cw_ready;
  logic        pkt_active;
  logic        pkt_parity;
  logic        flush;
  logic        key_en;
  logic        even_odd;
  logic [63:0] ck;
  logic        busy;
  logic        load_done;
  logic        even_key_valid;
  logic        odd_key_valid;

  int total;
  int bad;

  csa_key_loader #(
    .KS_CYCLES(56),
    .CNT_W    (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .even_cw_valid (even_cw_valid),
    .even_cw       (even_cw),
    .even_cw_ready (even_cw_ready),
    .odd_cw_valid  (odd_cw_valid),
    .odd_cw        (odd_cw),
    .odd_cw_ready  (odd_cw_ready),
    .pkt_active    (pkt_active),
    .pkt_parity    (pkt_parity),
    .flush         (flush),
    .key_en        (key_en),
    .even_odd      (even_odd),
    .ck            (ck),
    .busy          (busy),
    .load_done     (load_done),
    .even_key_valid(even_key_valid),
    .odd_key_valid (odd_key_valid)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n = falling edges waited until key_en is seen, -1 on timeout
  task automatic wait_key_en(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (key_en) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_load_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (load_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int busy_cnt;
    int ke_cnt;
    int ld_cnt;

    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    even_cw_valid = 1'b0;
    even_cw       = '0;
    odd_cw_valid  = 1'b0;
    odd_cw        = '0;
    pkt_active    = 1'b0;
    pkt_parity    = 1'b0;
    flush         = 1'b0;

    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    check("rst_key_en", key_en, 0);
    check("rst_busy", busy, 0);
    check("rst_load_done", load_done, 0);
    check("rst_even_valid", even_key_valid, 0);
    check("rst_odd_valid", odd_key_valid, 0);
    check("rst_even_odd", even_odd, 0);
    check("rst_ck", ck, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_even_ready", even_cw_ready, 1);
    check("rel_odd_ready", odd_cw_ready, 1);

    // ---- single even CW ----
    even_cw_valid = 1'b1;
    even_cw       = 64'h0123456789ABCDEF;
    @(negedge clk);                         // after E0
    even_cw_valid = 1'b0;
    check("t1_ready_low_E0", even_cw_ready, 0);
    check("t1_no_key_en_E0", key_en, 0);
    @(negedge clk);                         // after E1
    check("t1_key_en", key_en, 1);
    check("t1_ck", ck, 64'h0123456789ABCDEF);
    check("t1_even_odd", even_odd, 0);
    check("t1_busy_E1", busy, 1);
    check("t1_ready_high_E1", even_cw_ready, 1);
    busy_cnt = 1;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) check("t1_key_en_width", key_en, 0);
      if (busy) busy_cnt++;
      if (load_done) begin
        n = i;
        break;
      end
    end
    check("t1_load_done_lat", 64'(n), 64'd56);
    check("t1_busy_cycles", 64'(busy_cnt), 64'd56);
    check("t1_even_valid", even_key_valid, 1);
    check("t1_odd_valid", odd_key_valid, 0);
    @(negedge clk);
    check("t1_load_done_width", load_done, 0);

    // ---- both CWs on the same edge after reset ----
    do_reset();
    even_cw_valid = 1'b1;
    even_cw       = 64'hAAAA0000AAAA0000;
    odd_cw_valid  = 1'b1;
    odd_cw        = 64'h5555FFFF5555FFFF;
    @(negedge clk);
    even_cw_valid = 1'b0;
    odd_cw_valid  = 1'b0;
    wait_key_en(10, n);
    check("t2_first_lat", 64'(n), 64'd1);
    check("t2_first_parity", even_odd, 0);
    check("t2_first_ck", ck, 64'hAAAA0000AAAA0000);
    wait_key_en(200, n);
    check("t2_spacing", 64'(n), 64'd57);
    check("t2_second_parity", even_odd, 1);
    check("t2_second_ck", ck, 64'h5555FFFF5555FFFF);
    wait_load_done(100, n);
    check("t2_odd_done_lat", 64'(n), 64'd56);
    check("t2_even_valid", even_key_valid, 1);
    check("t2_odd_valid", odd_key_valid, 1);

    // ---- odd deferred by active odd packet; even reload meanwhile ----
    pkt_active   = 1'b1;
    pkt_parity   = 1'b1;
    odd_cw_valid = 1'b1;
    odd_cw       = 64'h1111111111111111;
    @(negedge clk);
    odd_cw_valid = 1'b0;
    check("t3_odd_pending", odd_cw_ready, 0);
    ke_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (key_en) ke_cnt++;
    end
    check("t3_no_key_en_active", 64'(ke_cnt), 64'd0);
    even_cw_valid = 1'b1;
    even_cw       = 64'h2222222222222222;
    @(negedge clk);
    even_cw_valid = 1'b0;
    wait_key_en(5, n);
    check("t3_even_immediate", 64'(n), 64'd1);
    check("t3_even_parity", even_odd, 0);
    check("t3_even_ck", ck, 64'h2222222222222222);
    check("t4_even_valid_drop", even_key_valid, 0);
    check("t4_odd_valid_kept", odd_key_valid, 1);
    wait_load_done(100, n);
    check("t4_even_done_lat", 64'(n), 64'd56);
    check("t4_even_valid_back", even_key_valid, 1);
    check("t4_odd_valid_still", odd_key_valid, 1);
    ke_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (key_en) ke_cnt++;
    end
    check("t3_still_deferred", 64'(ke_cnt), 64'd0);
    pkt_active = 1'b0;
    wait_key_en(5, n);
    check("t3_odd_after_drop", 64'(n), 64'd1);
    check("t3_odd_parity", even_odd, 1);
    check("t3_odd_ck", ck, 64'h1111111111111111);
    check("t3_odd_valid_drop", odd_key_valid, 0);
    wait_load_done(100, n);
    check("t3_odd_done_lat", 64'(n), 64'd56);
    check("t3_odd_valid_back", odd_key_valid, 1);

    // ---- flush during WAIT with both slots pending ----
    even_cw_valid = 1'b1;
    even_cw       = 64'h3333333333333333;
    @(negedge clk);
    even_cw_valid = 1'b0;
    wait_key_en(5, n);
    check("t5_issue_lat", 64'(n), 64'd1);
    even_cw_valid = 1'b1;
    even_cw       = 64'h4444444444444444;
    odd_cw_valid  = 1'b1;
    odd_cw        = 64'h6666666666666666;
    @(negedge clk);
    even_cw_valid = 1'b0;
    odd_cw_valid  = 1'b0;
    check("t5_even_pending", even_cw_ready, 0);
    check("t5_odd_pending", odd_cw_ready, 0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("t5_busy_before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t5_busy_after", busy, 0);
    check("t5_even_valid", even_key_valid, 0);
    check("t5_odd_valid", odd_key_valid, 0);
    check("t5_even_ready", even_cw_ready, 1);
    check("t5_odd_ready", odd_cw_ready, 1);
    check("t5_ck_kept", ck, 64'h3333333333333333);
    ke_cnt = 0;
    ld_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (key_en) ke_cnt++;
      if (load_done) ld_cnt++;
    end
    check("t5_no_key_en", 64'(ke_cnt), 64'd0);
    check("t5_no_load_done", 64'(ld_cnt), 64'd0);

    // ---- asynchronous reset mid-WAIT ----
    even_cw_valid = 1'b1;
    even_cw       = 64'h7777777777777777;
    @(negedge clk);
    even_cw_valid = 1'b0;
    wait_key_en(5, n);
    check("t6_issue_lat", 64'(n), 64'd1);
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_key_en", key_en, 0);
    check("t6_load_done", load_done, 0);
    check("t6_even_valid", even_key_valid, 0);
    check("t6_odd_valid", odd_key_valid, 0);
    check("t6_even_odd", even_odd, 0);
    check("t6_ck", ck, 0);
    @(negedge clk);
    rst = 1'b1;
    odd_cw_valid = 1'b1;
    odd_cw       = 64'h8888888888888888;
    @(negedge clk);
    odd_cw_valid = 1'b0;
    wait_key_en(5, n);
    check("t6_post_issue_lat", 64'(n), 64'd1);
    check("t6_post_parity", even_odd, 1);
    check("t6_post_ck", ck, 64'h8888888888888888);
    wait_load_done(100, n);
    check("t6_post_done_lat", 64'(n), 64'd56);
    check("t6_post_odd_valid", odd_key_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
